// File: rtl/serial_arith_pkg.sv
// -----------------------------------------------------------------------------
// serial_arith_pkg
// Shared definitions for the lab's bit-serial arithmetic blocks.
//   DEFAULT_WIDTH : default operand/result width
//   ST_IDLE/ST_SHIFT/ST_DONE : state encodings shared by the serial units
//   state_t       : enumerated FSM state type built on those encodings
// -----------------------------------------------------------------------------
package serial_arith_pkg;

   localparam int DEFAULT_WIDTH = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      SHIFT = ST_SHIFT,
      DONE  = ST_DONE
   } state_t;

endpackage

// File: rtl/full_add_cell.sv
// -----------------------------------------------------------------------------
// full_add_cell
// One-bit combinational full adder. Port names mirror the full-subtractor
// cell so both directions can be exercised by the same harness.
//   a, b  : addend bits
//   cin   : carry in
//   sum   : a ^ b ^ cin
//   cout  : majority(a, b, cin)
// -----------------------------------------------------------------------------
module full_add_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_unit.sv
// -----------------------------------------------------------------------------
// serial_add_unit
// Bit-serial adder: sum_out = diff_in + sub_in + cin (mod 2^WIDTH), one bit per
// clock, LSB first, through a single full_add_cell and a carry flop. Used to
// rebuild the minuend from a subtractor's difference and subtrahend.
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset, aborts any operation
//   start    : request, only honoured in IDLE
//   diff_in  : first addend, captured on accepted start
//   sub_in   : second addend, captured on accepted start
//   cin      : carry in, captured on accepted start
//   busy     : high during the WIDTH processing cycles
//   done     : one-cycle pulse once sum_out/cout are valid
//   sum_out  : result, held until the next operation completes
//   cout     : carry out of the MSB, held with sum_out
// -----------------------------------------------------------------------------
module serial_add_unit
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] diff_in,
   input  logic [WIDTH-1:0] sub_in,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout
);

   localparam int               CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   state_t             state_q;
   state_t             state_d;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   res_q;
   logic [WIDTH-1:0]   res_next;
   logic               c_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               fa_s;
   logic               fa_c;

   full_add_cell u_fa (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .cin  (c_q),
      .sum  (fa_s),
      .cout (fa_c)
   );

   // Result register after this cycle's bit enters at the MSB; on the last bit
   // this is the complete sum, so sum_out is loaded from it directly.
   assign res_next = {fa_s, res_q[WIDTH-1:1]};

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SHIFT;
         SHIFT:   if (cnt_q == LAST) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Both flags decode the state register, so they carry no input path.
   assign busy = (state_q == SHIFT);
   assign done = (state_q == DONE);

   // Operand capture, serial datapath and result hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         sum_out <= '0;
         cout    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_q   <= diff_in;
                  b_q   <= sub_in;
                  c_q   <= cin;
                  cnt_q <= '0;
               end
            end
            SHIFT: begin
               a_q   <= a_q >> 1;
               b_q   <= b_q >> 1;
               res_q <= res_next;
               c_q   <= fa_c;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  sum_out <= res_next;
                  cout    <= fa_c;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_unit.sv
// -----------------------------------------------------------------------------
// tb_serial_add_unit
// Scoreboard bench for serial_add_unit (WIDTH = 8). The stimulus process
// pushes each expected {cout, sum} when it issues an operation; the monitor
// pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_serial_add_unit;

   localparam int W = 8;

   logic         clk;
   logic         clk_en;
   logic         rst;
   logic         start;
   logic [W-1:0] diff_in;
   logic [W-1:0] sub_in;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum_out;
   logic         cout;

   int           total;
   int           bad;
   int           done_seen;
   int           ops_issued;
   int           blen;
   logic [W:0]   sb_q[$];

   serial_add_unit #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .diff_in (diff_in),
      .sub_in  (sub_in),
      .cin     (cin),
      .busy    (busy),
      .done    (done),
      .sum_out (sum_out),
      .cout    (cout)
   );

   initial begin
      clk = 1'b0;
      wait (clk_en);
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: scoreboard compare on done, busy run length, busy/done exclusion
   always @(negedge clk) begin
      if (rst) begin
         blen = 0;
      end else begin
         if (done) begin
            done_seen++;
            chk("busy_done_excl", 32'(busy), 32'd0);
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got sum=%0h cout=%0b expected no done", sum_out, cout);
            end else begin
               chk("result", 32'({cout, sum_out}), 32'(sb_q.pop_front()));
            end
         end
         if (busy) begin
            blen++;
         end else if (blen != 0) begin
            chk("busy_len", 32'(blen), 32'(W));
            blen = 0;
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while ((busy || done) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         total++;
         bad++;
         $display("FAIL wait_idle: got busy=%0b done=%0b expected idle", busy, done);
      end
   endtask

   // Issue one operation, push its expectation and measure done latency.
   task automatic do_op(input logic [W-1:0] d, input logic [W-1:0] s,
                        input logic c, input logic [W:0] exp);
      int lat;
      wait_idle();
      diff_in = d;
      sub_in  = s;
      cin     = c;
      start   = 1'b1;
      sb_q.push_back(exp);
      ops_issued++;
      @(posedge clk);
      #1;
      start   = 1'b0;
      // Operands must not be resampled after acceptance.
      diff_in = ~d;
      sub_in  = W'($urandom);
      cin     = ~c;
      lat = 0;
      while (lat < 30) begin
         @(negedge clk);
         if (done) break;
         lat++;
      end
      chk("done_latency", 32'(lat), 32'(W));
   endtask

   logic [W-1:0] vd[4];
   logic [W-1:0] vs[4];
   logic         vc[4];
   logic [W:0]   ve[4];

   initial begin
      logic [W-1:0] d;
      logic [W-1:0] s;
      logic         c;
      logic         a;
      logic         b;
      logic         bin;
      logic [W:0]   e;
      int           n;

      total = 0; bad = 0; done_seen = 0; ops_issued = 0; blen = 0;
      clk_en = 1'b0;
      rst = 1'b0; start = 1'b0; diff_in = '0; sub_in = '0; cin = 1'b0;

      // Reset with the clock stopped: outputs must clear asynchronously.
      #3 rst = 1'b1;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum_out), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);

      clk_en = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      do_op(8'h00, 8'h00, 1'b0, 9'h000);

      // Directed vectors, expected values worked by hand
      vd[0] = 8'h3C; vs[0] = 8'h05; vc[0] = 1'b0; ve[0] = 9'h041;
      vd[1] = 8'hFF; vs[1] = 8'h01; vc[1] = 1'b0; ve[1] = 9'h100;
      vd[2] = 8'hFF; vs[2] = 8'hFF; vc[2] = 1'b1; ve[2] = 9'h1FF;
      vd[3] = 8'h80; vs[3] = 8'h7F; vc[3] = 1'b1; ve[3] = 9'h100;
      for (int i = 0; i < 4; i++) do_op(vd[i], vs[i], vc[i], ve[i]);

      // Start requests during SHIFT and DONE are dropped
      wait_idle();
      diff_in = 8'h10; sub_in = 8'h20; cin = 1'b0; start = 1'b1;
      sb_q.push_back(9'h030);
      ops_issued++;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1 start = 1'b1; diff_in = 8'hAA; sub_in = 8'h55;
      @(posedge clk);
      #1 start = 1'b0; diff_in = 8'hFF;
      n = 0;
      while (n < 30) begin
         @(negedge clk);
         if (done) break;
         n++;
      end
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      chk("ignore_busy", 32'(busy), 32'd0);
      chk("ignore_sum_held", 32'(sum_out), 32'h30);
      chk("ignore_cout_held", 32'(cout), 32'd0);

      // Abort after bit 3 of 0x0F + 0x01
      wait_idle();
      diff_in = 8'h0F; sub_in = 8'h01; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_sum", 32'(sum_out), 32'd0);
      chk("abort_cout", 32'(cout), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      do_op(8'h0F, 8'h01, 1'b0, 9'h010);

      // Round trip through all one-bit full-subtractor vectors
      for (int i = 0; i < 8; i++) begin
         a   = i[2];
         b   = i[1];
         bin = i[0];
         d   = W'({7'd0, a} - {7'd0, b} - {7'd0, bin});
         s   = {7'd0, b};
         e   = {1'b0, d} + {1'b0, s} + {8'd0, bin};
         do_op(d, s, bin, e);
      end

      // Random operands against the reference sum
      for (int i = 0; i < 1000; i++) begin
         d = W'($urandom);
         s = W'($urandom);
         c = 1'($urandom);
         e = {1'b0, d} + {1'b0, s} + {8'd0, c};
         do_op(d, s, c, e);
      end

      n = 0;
      while (sb_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      repeat (3) @(negedge clk);
      chk("done_count", 32'(done_seen), 32'(ops_issued));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
